// File: rtl/csi2tx_sensor_pattern_gen_pkg.sv
// Shared types and constants for the CSI-2 synthetic sensor source.
// Covers the FSM state encoding, short-packet data types and the PRBS32 step.
package csi2tx_sensor_pattern_gen_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FS_HDR    = 4'd1,
    ST_LS_HDR    = 4'd2,
    ST_LINE_HDR  = 4'd3,
    ST_PAYLOAD   = 4'd4,
    ST_LE_HDR    = 4'd5,
    ST_LINE_GAP  = 4'd6,
    ST_FE_HDR    = 4'd7,
    ST_FRAME_GAP = 4'd8
  } state_t;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  localparam logic [31:0] PRBS_SEED = 32'hFFFF_FFFF;

  // Fibonacci form of x^32 + x^22 + x^2 + x + 1, shifting towards the MSB.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

endpackage

// File: rtl/csi2tx_tpg_lfsr.sv
// 32-bit PRBS generator for the pattern source; exposes its next value so the
// payload register can be loaded in the same cycle the LFSR is reseeded or stepped.
module csi2tx_tpg_lfsr
  import csi2tx_sensor_pattern_gen_pkg::*;
(
  input  logic        clk_csi,
  input  logic        clk_csi_rst_n,
  input  logic        seed_load,
  input  logic        advance,
  output logic [31:0] value_next
);

  logic [31:0] value_reg;

  always_comb begin
    value_next = value_reg;
    if (seed_load) begin
      value_next = PRBS_SEED;
    end else if (advance) begin
      value_next = lfsr_step(value_reg);
    end
  end

  always_ff @(posedge clk_csi or negedge clk_csi_rst_n) begin
    if (!clk_csi_rst_n) begin
      value_reg <= PRBS_SEED;
    end else begin
      value_reg <= value_next;
    end
  end

endmodule

// File: rtl/csi2tx_sensor_pattern_gen.sv
// Synthetic camera sensor: emits complete CSI-2 frames (FS/LS/LE/FE short packets,
// line headers and 32-bit payload) under valid/accept handshakes. All outputs registered.
module csi2tx_sensor_pattern_gen
  import csi2tx_sensor_pattern_gen_pkg::*;
#(
  parameter int WC_W       = 16,
  parameter int LINE_CNT_W = 16,
  parameter int GAP_W      = 12
) (
  input  logic                  clk_csi,
  input  logic                  clk_csi_rst_n,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_vc,
  input  logic [5:0]            cfg_dt,
  input  logic [WC_W-1:0]       cfg_line_bytes,
  input  logic [LINE_CNT_W-1:0] cfg_num_lines,
  input  logic                  cfg_ls_le_en,
  input  logic [1:0]            cfg_pattern,
  input  logic [31:0]           cfg_fill,
  input  logic [GAP_W-1:0]      cfg_line_gap,
  input  logic [GAP_W-1:0]      cfg_frame_gap,
  input  logic                  packet_header_accept,
  input  logic                  pixel_data_accept,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  line_start,
  output logic                  line_end,
  output logic                  packet_header_valid,
  output logic [1:0]            virtual_channel,
  output logic [5:0]            data_type,
  output logic [WC_W-1:0]       word_count,
  output logic                  pixel_data_valid,
  output logic [31:0]           pixel_data,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  typedef struct packed {
    logic [1:0]            vc;
    logic [5:0]            dt;
    logic [WC_W-1:0]       line_bytes;
    logic [LINE_CNT_W-1:0] num_lines;
    logic                  ls_le_en;
    logic [1:0]            pattern;
    logic [31:0]           fill;
    logic [GAP_W-1:0]      line_gap;
    logic [GAP_W-1:0]      frame_gap;
  } shadow_t;

  state_t                state_reg, state_next;
  shadow_t               sh_reg, sh_next;
  logic [LINE_CNT_W-1:0] line_reg, line_next;
  logic [WC_W-1:0]       beat_reg, beat_next;
  logic [GAP_W-1:0]      gap_reg, gap_next;
  logic [WC_W-1:0]       last_beat;
  logic                  last_line;
  logic                  load_cfg, lfsr_advance, fc_inc;
  logic                  payload_done, line_done, next_line, frame_done, next_frame;
  logic [31:0]           prbs_next;
  logic [31:0]           byte_base, bytes_left, beat_data_next;

  logic                  hv_next, fs_next, fe_next, ls_next, le_next, pv_next, busy_next;
  logic [1:0]            vc_next;
  logic [5:0]            dt_next;
  logic [WC_W-1:0]       wc_next;
  logic [31:0]           pd_next;

  csi2tx_tpg_lfsr u_lfsr (
    .clk_csi       (clk_csi),
    .clk_csi_rst_n (clk_csi_rst_n),
    .seed_load     (load_cfg),
    .advance       (lfsr_advance),
    .value_next    (prbs_next)
  );

  assign last_beat = (sh_reg.line_bytes - WC_W'(1)) >> 2;
  assign last_line = (line_reg == sh_reg.num_lines - LINE_CNT_W'(1));

  always_ff @(posedge clk_csi or negedge clk_csi_rst_n) begin
    if (!clk_csi_rst_n) begin
      state_reg <= ST_IDLE;
      sh_reg    <= '0;
      line_reg  <= '0;
      beat_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      line_reg  <= line_next;
      beat_reg  <= beat_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state: the done/next flags chain so every way of finishing a line or frame
  // shares one exit path, including the zero-gap and zero-length shortcuts.
  always_comb begin
    state_next   = state_reg;
    line_next    = line_reg;
    beat_next    = beat_reg;
    gap_next     = gap_reg;
    load_cfg     = 1'b0;
    lfsr_advance = 1'b0;
    fc_inc       = 1'b0;
    payload_done = 1'b0;
    line_done    = 1'b0;
    next_line    = 1'b0;
    frame_done   = 1'b0;
    next_frame   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_next = ST_FS_HDR;
          load_cfg   = 1'b1;
        end
      end
      ST_FS_HDR: begin
        if (packet_header_accept) begin
          line_next = '0;
          if (sh_reg.num_lines == '0) begin
            state_next = ST_FE_HDR;
          end else begin
            state_next = sh_reg.ls_le_en ? ST_LS_HDR : ST_LINE_HDR;
          end
        end
      end
      ST_LS_HDR: begin
        if (packet_header_accept) begin
          state_next = ST_LINE_HDR;
        end
      end
      ST_LINE_HDR: begin
        if (packet_header_accept) begin
          beat_next = '0;
          if (sh_reg.line_bytes == '0) begin
            payload_done = 1'b1;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pixel_data_accept) begin
          lfsr_advance = 1'b1;
          if (beat_reg == last_beat) begin
            payload_done = 1'b1;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      ST_LE_HDR: begin
        if (packet_header_accept) begin
          line_done = 1'b1;
        end
      end
      ST_LINE_GAP: begin
        if (gap_reg <= GAP_W'(1)) begin
          next_line = 1'b1;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      ST_FE_HDR: begin
        if (packet_header_accept) begin
          fc_inc     = 1'b1;
          frame_done = 1'b1;
        end
      end
      ST_FRAME_GAP: begin
        if (gap_reg <= GAP_W'(1)) begin
          next_frame = 1'b1;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (payload_done) begin
      if (sh_reg.ls_le_en) begin
        state_next = ST_LE_HDR;
      end else begin
        line_done = 1'b1;
      end
    end
    if (line_done) begin
      if (sh_reg.line_gap != '0) begin
        state_next = ST_LINE_GAP;
        gap_next   = sh_reg.line_gap;
      end else begin
        next_line = 1'b1;
      end
    end
    if (next_line) begin
      if (last_line) begin
        state_next = ST_FE_HDR;
      end else begin
        line_next  = line_reg + 1'b1;
        state_next = sh_reg.ls_le_en ? ST_LS_HDR : ST_LINE_HDR;
      end
    end
    if (frame_done) begin
      if (sh_reg.frame_gap != '0) begin
        state_next = ST_FRAME_GAP;
        gap_next   = sh_reg.frame_gap;
      end else begin
        next_frame = 1'b1;
      end
    end
    if (next_frame) begin
      if (cfg_enable) begin
        state_next = ST_FS_HDR;
        load_cfg   = 1'b1;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    sh_next = sh_reg;
    if (load_cfg) begin
      sh_next.vc         = cfg_vc;
      sh_next.dt         = cfg_dt;
      sh_next.line_bytes = cfg_line_bytes;
      sh_next.num_lines  = cfg_num_lines;
      sh_next.ls_le_en   = cfg_ls_le_en;
      sh_next.pattern    = cfg_pattern;
      sh_next.fill       = cfg_fill;
      sh_next.line_gap   = cfg_line_gap;
      sh_next.frame_gap  = cfg_frame_gap;
    end
  end

  // Payload byte lanes; lanes past the end of the line are forced to zero.
  assign byte_base  = 32'(beat_next) << 2;
  assign bytes_left = 32'(sh_next.line_bytes) - byte_base;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_byte;
      always_comb begin
        case (sh_next.pattern)
          2'b00:   lane_byte = byte_base[7:0] + 8'(gi);
          2'b01:   lane_byte = sh_next.fill[8*gi +: 8];
          2'b10:   lane_byte = line_next[7:0];
          default: lane_byte = prbs_next[8*gi +: 8];
        endcase
      end
      assign beat_data_next[8*gi +: 8] = (bytes_left > 32'(gi)) ? lane_byte : 8'h00;
    end
  endgenerate

  // Outputs are decoded from the upcoming state so the registers line up with state_reg.
  always_comb begin
    hv_next   = 1'b0;
    fs_next   = 1'b0;
    fe_next   = 1'b0;
    ls_next   = 1'b0;
    le_next   = 1'b0;
    vc_next   = 2'b00;
    dt_next   = 6'h00;
    wc_next   = '0;
    pv_next   = 1'b0;
    pd_next   = 32'h0;
    busy_next = (state_next != ST_IDLE);
    case (state_next)
      ST_FS_HDR: begin
        hv_next = 1'b1;
        fs_next = 1'b1;
        vc_next = sh_next.vc;
        dt_next = DT_FS;
      end
      ST_LS_HDR: begin
        hv_next = 1'b1;
        ls_next = 1'b1;
        vc_next = sh_next.vc;
        dt_next = DT_LS;
      end
      ST_LINE_HDR: begin
        hv_next = 1'b1;
        vc_next = sh_next.vc;
        dt_next = sh_next.dt;
        wc_next = sh_next.line_bytes;
      end
      ST_PAYLOAD: begin
        pv_next = 1'b1;
        pd_next = beat_data_next;
      end
      ST_LE_HDR: begin
        hv_next = 1'b1;
        le_next = 1'b1;
        vc_next = sh_next.vc;
        dt_next = DT_LE;
      end
      ST_FE_HDR: begin
        hv_next = 1'b1;
        fe_next = 1'b1;
        vc_next = sh_next.vc;
        dt_next = DT_FE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_csi or negedge clk_csi_rst_n) begin
    if (!clk_csi_rst_n) begin
      packet_header_valid <= 1'b0;
      frame_start         <= 1'b0;
      frame_end           <= 1'b0;
      line_start          <= 1'b0;
      line_end            <= 1'b0;
      virtual_channel     <= 2'b00;
      data_type           <= 6'h00;
      word_count          <= '0;
      pixel_data_valid    <= 1'b0;
      pixel_data          <= 32'h0;
      busy                <= 1'b0;
      frame_count         <= 16'h0;
    end else begin
      packet_header_valid <= hv_next;
      frame_start         <= fs_next;
      frame_end           <= fe_next;
      line_start          <= ls_next;
      line_end            <= le_next;
      virtual_channel     <= vc_next;
      data_type           <= dt_next;
      word_count          <= wc_next;
      pixel_data_valid    <= pv_next;
      pixel_data          <= pd_next;
      busy                <= busy_next;
      if (fc_inc) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
